// File: rtl/register_bank_dehl.sv
// D/E/H/L register bank with optional shadow set, EX/EXX swaps, pair inc/dec and ALU write-back.
// One command per cycle; outputs and their complements come straight from the registers.
module register_bank_dehl #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SHADOW = 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             PR_Write,
  input  logic [1:0]       WriteSel,
  input  logic [WIDTH-1:0] notALUResult,
  input  logic             PR_Ex,
  input  logic             PR_Exx,
  input  logic             PR_PairInc,
  input  logic             PR_PairDec,
  input  logic             PairSel,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] E,
  output logic [WIDTH-1:0] H,
  output logic [WIDTH-1:0] L,
  output logic [WIDTH-1:0] notD,
  output logic [WIDTH-1:0] notE,
  output logic [WIDTH-1:0] notH,
  output logic [WIDTH-1:0] notL,
  output logic             PairZero
);

  localparam logic [2*WIDTH-1:0] PairOne = {{(2*WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] d_q, e_q, h_q, l_q;
  logic [WIDTH-1:0] d_d, e_d, h_d, l_d;
  logic [WIDTH-1:0] sd_q, se_q, sh_q, sl_q;
  logic [WIDTH-1:0] sd_d, se_d, sh_d, sl_d;
  logic             pair_zero_q, pair_zero_d;

  logic             exx_en;
  logic [2*WIDTH-1:0] pair_cur, pair_nxt;

  // Without a shadow bank EXX is simply not a command, so it must not block lower priorities.
  assign exx_en   = PR_Exx && (SHADOW != 0);
  assign pair_cur = PairSel ? {h_q, l_q} : {d_q, e_q};
  assign pair_nxt = PR_PairInc ? (pair_cur + PairOne) : (pair_cur - PairOne);

  always_comb begin
    d_d         = d_q;
    e_d         = e_q;
    h_d         = h_q;
    l_d         = l_q;
    sd_d        = sd_q;
    se_d        = se_q;
    sh_d        = sh_q;
    sl_d        = sl_q;
    pair_zero_d = pair_zero_q;

    if (exx_en) begin
      d_d  = sd_q;
      e_d  = se_q;
      h_d  = sh_q;
      l_d  = sl_q;
      sd_d = d_q;
      se_d = e_q;
      sh_d = h_q;
      sl_d = l_q;
    end else if (PR_Ex) begin
      d_d = h_q;
      e_d = l_q;
      h_d = d_q;
      l_d = e_q;
    end else if (PR_PairInc || PR_PairDec) begin
      if (PairSel) begin
        {h_d, l_d} = pair_nxt;
      end else begin
        {d_d, e_d} = pair_nxt;
      end
      pair_zero_d = (pair_nxt == '0);
    end else if (PR_Write) begin
      unique case (WriteSel)
        2'd0: d_d = ~notALUResult;
        2'd1: e_d = ~notALUResult;
        2'd2: h_d = ~notALUResult;
        2'd3: l_d = ~notALUResult;
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      d_q         <= '0;
      e_q         <= '0;
      h_q         <= '0;
      l_q         <= '0;
      sd_q        <= '0;
      se_q        <= '0;
      sh_q        <= '0;
      sl_q        <= '0;
      pair_zero_q <= 1'b0;
    end else begin
      d_q         <= d_d;
      e_q         <= e_d;
      h_q         <= h_d;
      l_q         <= l_d;
      sd_q        <= sd_d;
      se_q        <= se_d;
      sh_q        <= sh_d;
      sl_q        <= sl_d;
      pair_zero_q <= pair_zero_d;
    end
  end

  assign D        = d_q;
  assign E        = e_q;
  assign H        = h_q;
  assign L        = l_q;
  assign notD     = ~d_q;
  assign notE     = ~e_q;
  assign notH     = ~h_q;
  assign notL     = ~l_q;
  assign PairZero = pair_zero_q;

endmodule

// File: tb/tb_register_bank_dehl.sv
// Scoreboard bench: drives a SHADOW=1 and a SHADOW=0 bank with shared stimulus and checks both
// against an array/integer model of the register bank.
module tb_register_bank_dehl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr = 1'b0, ex = 1'b0, exx = 1'b0, inc = 1'b0, dec = 1'b0, psel = 1'b0;
  logic [1:0] wsel = '0;
  logic [7:0] nres = '0;

  logic [7:0] d1, e1, h1, l1, nd1, ne1, nh1, nl1;
  logic [7:0] d0, e0, h0, l0, nd0, ne0, nh0, nl0;
  logic       pz1, pz0;

  always #5 clk = ~clk;

  register_bank_dehl #(.WIDTH(8), .SHADOW(1)) dut1 (
    .Clk(clk), .Reset(rst), .PR_Write(wr), .WriteSel(wsel), .notALUResult(nres),
    .PR_Ex(ex), .PR_Exx(exx), .PR_PairInc(inc), .PR_PairDec(dec), .PairSel(psel),
    .D(d1), .E(e1), .H(h1), .L(l1), .notD(nd1), .notE(ne1), .notH(nh1), .notL(nl1),
    .PairZero(pz1)
  );

  register_bank_dehl #(.WIDTH(8), .SHADOW(0)) dut0 (
    .Clk(clk), .Reset(rst), .PR_Write(wr), .WriteSel(wsel), .notALUResult(nres),
    .PR_Ex(ex), .PR_Exx(exx), .PR_PairInc(inc), .PR_PairDec(dec), .PairSel(psel),
    .D(d0), .E(e0), .H(h0), .L(l0), .notD(nd0), .notE(ne0), .notH(nh0), .notL(nl0),
    .PairZero(pz0)
  );

  typedef struct packed {
    logic       rst, exx, ex, inc, dec, wr;
    logic [1:0] wsel;
    logic [7:0] nres;
    logic       psel;
  } cmd_t;

  // r/s index 0..3 = D, E, H, L
  typedef struct packed {
    logic [3:0][7:0] r;
    logic [3:0][7:0] s;
    logic            pz;
  } model_t;

  typedef struct packed {
    model_t m1;
    model_t m0;
  } exp_t;

  model_t m1 = '0, m0 = '0;
  exp_t   sb_q[$];
  int     checks = 0;
  int     errors = 0;

  function automatic model_t step(model_t m, bit shadow, cmd_t c);
    model_t n = m;
    int unsigned v;
    int hi;
    if (c.rst) return '0;
    if (c.exx && shadow) begin
      n.r = m.s;
      n.s = m.r;
    end else if (c.ex) begin
      n.r[0] = m.r[2]; n.r[2] = m.r[0];
      n.r[1] = m.r[3]; n.r[3] = m.r[1];
    end else if (c.inc || c.dec) begin
      hi = c.psel ? 2 : 0;
      v  = int'(m.r[hi]) * 256 + int'(m.r[hi+1]);
      v  = c.inc ? (v + 1) % 65536 : (v + 65535) % 65536;
      n.r[hi]   = v[15:8];
      n.r[hi+1] = v[7:0];
      n.pz      = (v == 0);
    end else if (c.wr) begin
      n.r[c.wsel] = ~c.nres;
    end
    return n;
  endfunction

  task automatic issue(cmd_t c);
    @(negedge clk);
    rst = c.rst; exx = c.exx; ex = c.ex; inc = c.inc; dec = c.dec; wr = c.wr;
    wsel = c.wsel; nres = c.nres; psel = c.psel;
    m1 = step(m1, 1'b1, c);
    m0 = step(m0, 1'b0, c);
    sb_q.push_back('{m1: m1, m0: m0});
  endtask

  function automatic cmd_t idle();
    return '0;
  endfunction

  task automatic do_write(int sel, logic [7:0] val);
    cmd_t c = idle();
    c.wr = 1'b1; c.wsel = 2'(sel); c.nres = ~val;
    issue(c);
  endtask

  task automatic load(logic [7:0] a, logic [7:0] b, logic [7:0] x, logic [7:0] y);
    do_write(0, a); do_write(1, b); do_write(2, x); do_write(3, y);
  endtask

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every output update after a driven edge is compared against the scoreboard head.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        x = sb_q.pop_front();
        chk("s1_D", d1, x.m1.r[0]);  chk("s1_E", e1, x.m1.r[1]);
        chk("s1_H", h1, x.m1.r[2]);  chk("s1_L", l1, x.m1.r[3]);
        chk("s1_notD", nd1, ~x.m1.r[0]); chk("s1_notE", ne1, ~x.m1.r[1]);
        chk("s1_notH", nh1, ~x.m1.r[2]); chk("s1_notL", nl1, ~x.m1.r[3]);
        chk("s1_PairZero", {7'd0, pz1}, {7'd0, x.m1.pz});
        chk("s0_D", d0, x.m0.r[0]);  chk("s0_E", e0, x.m0.r[1]);
        chk("s0_H", h0, x.m0.r[2]);  chk("s0_L", l0, x.m0.r[3]);
        chk("s0_notD", nd0, ~x.m0.r[0]); chk("s0_notE", ne0, ~x.m0.r[1]);
        chk("s0_notH", nh0, ~x.m0.r[2]); chk("s0_notL", nl0, ~x.m0.r[3]);
        chk("s0_PairZero", {7'd0, pz0}, {7'd0, x.m0.pz});
      end
    end
  end

  initial begin
    cmd_t c;
    // Reset with every command high, then the same commands without reset.
    c = '{rst: 1'b1, exx: 1'b1, ex: 1'b1, inc: 1'b1, dec: 1'b1, wr: 1'b1,
          wsel: 2'd2, nres: 8'hA5, psel: 1'b1};
    issue(c);
    c.rst = 1'b0;
    issue(c);
    c = idle(); c.rst = 1'b1; issue(c);
    issue(idle());
    // Writes to each register
    do_write(2, 8'h5A);
    do_write(0, 8'h3C); do_write(1, 8'hC3); do_write(3, 8'h81);
    // EX twice
    load(8'h12, 8'h34, 8'h56, 8'h78);
    c = idle(); c.ex = 1'b1; issue(c); issue(c);
    // EXX with shadow round-trip
    load(8'h11, 8'h22, 8'h33, 8'h44);
    c = idle(); c.exx = 1'b1; issue(c);
    do_write(0, 8'h99);
    issue(c); issue(c);
    // Pair increment/decrement boundaries
    do_write(0, 8'h00); do_write(1, 8'hFF);
    c = idle(); c.inc = 1'b1; c.psel = 1'b0; issue(c);
    do_write(2, 8'hFF); do_write(3, 8'hFF);
    c = idle(); c.inc = 1'b1; c.psel = 1'b1; issue(c);
    issue(idle());
    c = idle(); c.dec = 1'b1; c.psel = 1'b1; issue(c);
    // PairZero holds through other commands
    c = idle(); c.inc = 1'b1; c.psel = 1'b1; issue(c);
    do_write(0, 8'h07);
    c = idle(); c.ex = 1'b1; issue(c);
    // Simultaneous EXX + EX + Write: EXX only on SHADOW=1, EX only on SHADOW=0
    load(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    c = idle(); c.exx = 1'b1; c.ex = 1'b1; c.wr = 1'b1; c.nres = 8'h00; issue(c);
    // Inc and Dec together: inc wins
    c = idle(); c.inc = 1'b1; c.dec = 1'b1; issue(c);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      c.rst  = ($urandom_range(39) == 0);
      c.exx  = ($urandom_range(5) == 0);
      c.ex   = ($urandom_range(5) == 0);
      c.inc  = ($urandom_range(4) == 0);
      c.dec  = ($urandom_range(4) == 0);
      c.wr   = ($urandom_range(1) == 0);
      c.wsel = 2'($urandom_range(3));
      c.nres = 8'($urandom_range(255));
      c.psel = 1'($urandom_range(1));
      issue(c);
    end
    issue(idle());
    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
    #2;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
